// File: rtl/afifo_fwft_reader_if.sv
// rtl/afifo_fwft_reader_if.sv - FIFO read-port and FWFT stream signal bundle
interface afifo_fwft_reader_if #(
    parameter int DataWidth = 8
);
    logic                 FIFOempty;
    logic                 RDen;
    logic [DataWidth-1:0] RDdata;
    logic                 RDreq;
    logic [DataWidth-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic [1:0]           occupancy;

    // The reader side: consumes the FIFO port, produces the stream.
    modport master (
        input  FIFOempty,
        input  RDen,
        input  RDdata,
        input  dout_ready,
        output RDreq,
        output dout,
        output dout_valid,
        output occupancy
    );

    // The surrounding logic: FIFO control plus the downstream sink.
    modport slave (
        output FIFOempty,
        output RDen,
        output RDdata,
        output dout_ready,
        input  RDreq,
        input  dout,
        input  dout_valid,
        input  occupancy
    );
endinterface

// File: rtl/afifo_fwft_reader.sv
// rtl/afifo_fwft_reader.sv - async FIFO read port to first-word-fall-through stream
module afifo_fwft_reader #(
    parameter int DataWidth = 8
) (
    input  logic                RDclk,
    input  logic                reset,
    afifo_fwft_reader_if.master rd
);
    // buf0 is the head of the stream, buf1 the skid slot; v1 implies v0.
    logic [DataWidth-1:0] buf0;
    logic [DataWidth-1:0] buf1;
    logic                 v0;
    logic                 v1;
    logic                 inflight;
    logic                 pop;
    logic [1:0]           occ;

    // Stream outputs, occupancy and the read request are all combinational.
    // A request is allowed whenever a slot will exist when its data lands:
    // either fewer than two words are committed, or one leaves this cycle.
    always_comb begin
        pop           = v0 & rd.dout_ready;
        occ           = {1'b0, v0} + {1'b0, v1} + {1'b0, inflight};
        rd.RDreq      = !reset & !rd.FIFOempty & ((occ < 2'd2) | pop);
        rd.dout       = buf0;
        rd.dout_valid = v0;
        rd.occupancy  = occ;
    end

    // Track the granted read and move words through the two-entry buffer,
    // popping from the head and capturing returning data behind it.
    always_ff @(posedge RDclk or posedge reset) begin
        if (reset) begin
            buf0     <= '0;
            buf1     <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd.RDen;
            if (pop && v1) begin
                buf0 <= buf1;
                if (inflight) begin
                    buf1 <= rd.RDdata;
                end else begin
                    v1 <= 1'b0;
                end
            end else if (pop) begin
                if (inflight) begin
                    buf0 <= rd.RDdata;
                end else begin
                    v0 <= 1'b0;
                end
            end else if (inflight) begin
                if (!v0) begin
                    buf0 <= rd.RDdata;
                    v0   <= 1'b1;
                end else begin
                    buf1 <= rd.RDdata;
                    v1   <= 1'b1;
                end
            end
        end
    end
endmodule
